// File: rtl/cdb_arbiter_if.sv
// Common data bus arbiter interface: FU completion inputs, per-FU back-pressure
// and the registered ROB writeback port.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned GPR_SIZE     = 64,
  parameter int unsigned ROB_IDX_SIZE = 4
);
  localparam int unsigned SrcW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]              in_fu_done;
  logic [NUM_REQ*ROB_IDX_SIZE-1:0] in_fu_dst_rob_index;
  logic [NUM_REQ*GPR_SIZE-1:0]     in_fu_value;
  logic [NUM_REQ-1:0]              in_fu_set_nzcv;
  logic [NUM_REQ*4-1:0]            in_fu_nzcv;
  logic [NUM_REQ-1:0]              out_fu_ready;
  logic                            in_rob_ready;
  logic                            out_rob_done;
  logic [ROB_IDX_SIZE-1:0]         out_rob_dst_rob_index;
  logic [GPR_SIZE-1:0]             out_rob_value;
  logic                            out_rob_set_nzcv;
  logic [3:0]                      out_rob_nzcv;
  logic [SrcW-1:0]                 out_rob_src_id;

  // Driven by the FUs and the ROB.
  modport master (
    output in_fu_done, in_fu_dst_rob_index, in_fu_value, in_fu_set_nzcv, in_fu_nzcv,
    output in_rob_ready,
    input  out_fu_ready, out_rob_done, out_rob_dst_rob_index, out_rob_value,
    input  out_rob_set_nzcv, out_rob_nzcv, out_rob_src_id
  );

  // Seen by the arbiter.
  modport slave (
    input  in_fu_done, in_fu_dst_rob_index, in_fu_value, in_fu_set_nzcv, in_fu_nzcv,
    input  in_rob_ready,
    output out_fu_ready, out_rob_done, out_rob_dst_rob_index, out_rob_value,
    output out_rob_set_nzcv, out_rob_nzcv, out_rob_src_id
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per FU, round-robin selection of one
// completion per cycle into a registered ROB writeback port, with flush.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned GPR_SIZE     = 64,
  parameter int unsigned ROB_IDX_SIZE = 4
) (
  input logic          in_clk,
  input logic          in_rst,
  input logic          in_flush,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned SrcW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [ROB_IDX_SIZE-1:0] idx;
    logic [GPR_SIZE-1:0]     value;
    logic                    set_nzcv;
    logic [3:0]              nzcv;
  } payload_t;

  logic [NUM_REQ-1:0] slot_valid_q, slot_valid_d;
  payload_t           slot_q [NUM_REQ];
  payload_t           slot_d [NUM_REQ];
  payload_t           fu_in  [NUM_REQ];
  logic               rob_done_q, rob_done_d;
  payload_t           rob_q, rob_d;
  logic [SrcW-1:0]    src_id_q, src_id_d;
  logic [SrcW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] fu_ready;
  logic [SrcW-1:0]    grant_id;
  logic               grant_any;
  logic               out_free;

  // Unpack the flat per-FU completion buses.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      fu_in[i].idx      = bus.in_fu_dst_rob_index[i*ROB_IDX_SIZE +: ROB_IDX_SIZE];
      fu_in[i].value    = bus.in_fu_value[i*GPR_SIZE +: GPR_SIZE];
      fu_in[i].set_nzcv = bus.in_fu_set_nzcv[i];
      fu_in[i].nzcv     = bus.in_fu_nzcv[i*4 +: 4];
    end
  end

  // Round-robin grant: first valid slot at or after rr_ptr, only when the output can take it.
  always_comb begin
    int pos;
    out_free  = !rob_done_q || bus.in_rob_ready;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    pos       = 0;
    if (out_free) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        pos = int'(rr_ptr_q) + k;
        if (pos >= int'(NUM_REQ)) pos = pos - int'(NUM_REQ);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
          if (!grant_any && (pos == i) && slot_valid_q[i]) begin
            grant_any = 1'b1;
            grant[i]  = 1'b1;
            grant_id  = SrcW'(i);
          end
        end
      end
    end
  end

  // A slot may accept when empty or draining this cycle; flush and reset block all FUs.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      fu_ready[i] = in_rst && !in_flush && (!slot_valid_q[i] || grant[i]);
    end
  end

  // Next state: flush clears everything but rr_ptr; otherwise grant then capture.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_d       = slot_q;
    rob_done_d   = rob_done_q;
    rob_d        = rob_q;
    src_id_d     = src_id_q;
    rr_ptr_d     = rr_ptr_q;
    if (in_flush) begin
      slot_valid_d = '0;
      rob_done_d   = 1'b0;
    end else begin
      if (grant_any) begin
        rob_done_d = 1'b1;
        src_id_d   = grant_id;
        rr_ptr_d   = (grant_id == SrcW'(NUM_REQ - 1)) ? '0 : grant_id + SrcW'(1);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
          if (grant[i]) begin
            rob_d           = slot_q[i];
            slot_valid_d[i] = 1'b0;
          end
        end
      end else if (out_free) begin
        rob_done_d = 1'b0;
      end
      // Capture after the drain so a same-cycle refill keeps the slot valid.
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (bus.in_fu_done[i] && fu_ready[i]) begin
          slot_d[i]       = fu_in[i];
          slot_valid_d[i] = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      slot_valid_q <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) slot_q[i] <= '0;
      rob_done_q   <= 1'b0;
      rob_q        <= '0;
      src_id_q     <= '0;
      rr_ptr_q     <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_q       <= slot_d;
      rob_done_q   <= rob_done_d;
      rob_q        <= rob_d;
      src_id_q     <= src_id_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign bus.out_fu_ready          = fu_ready;
  assign bus.out_rob_done          = rob_done_q;
  assign bus.out_rob_dst_rob_index = rob_q.idx;
  assign bus.out_rob_value         = rob_q.value;
  assign bus.out_rob_set_nzcv      = rob_q.set_nzcv;
  assign bus.out_rob_nzcv          = rob_q.nzcv;
  assign bus.out_rob_src_id        = src_id_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand sequences for reset/flush and
// back-to-back traffic, and randomized traffic against a behavioural model.
module tb_cdb_arbiter;
  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   failures;

  cdb_arbiter_if #(.NUM_REQ(2), .GPR_SIZE(64), .ROB_IDX_SIZE(4)) bus ();

  cdb_arbiter #(.NUM_REQ(2), .GPR_SIZE(64), .ROB_IDX_SIZE(4)) dut (
    .in_clk  (clk),
    .in_rst  (rst),
    .in_flush(flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state.
  int          m_rr;
  logic        m_valid [2];
  logic [3:0]  m_idx   [2];
  logic [63:0] m_val   [2];
  logic        m_set   [2];
  logic [3:0]  m_nz    [2];
  logic        m_done, m_oset, m_src, m_rstd;
  logic [3:0]  m_oidx, m_onz;
  logic [63:0] m_oval;

  typedef struct {
    logic        flush;
    logic [1:0]  done;
    logic [3:0]  idx0;
    logic [63:0] val0;
    logic [3:0]  idx1;
    logic [63:0] val1;
    logic        rob_ready;
    logic [1:0]  exp_ready;
    logic        exp_done;
    logic        exp_src;
    logic [3:0]  exp_idx;
    logic [63:0] exp_val;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic f, input logic [1:0] d, input logic [3:0] i0,
                              input logic [63:0] v0, input logic [3:0] i1, input logic [63:0] v1,
                              input logic rr, input logic [1:0] er, input logic ed,
                              input logic es, input logic [3:0] ei, input logic [63:0] ev);
    vec_t v;
    v.flush = f; v.done = d; v.idx0 = i0; v.val0 = v0; v.idx1 = i1; v.val1 = v1;
    v.rob_ready = rr; v.exp_ready = er; v.exp_done = ed; v.exp_src = es;
    v.exp_idx = ei; v.exp_val = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slot granted this cycle, or -1; the output must be empty or being consumed.
  function automatic int m_grant();
    if (m_done && !bus.in_rob_ready) return -1;
    for (int k = 0; k < 2; k++) begin
      int j;
      j = (m_rr + k) % 2;
      if (m_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic m_ready(input int i);
    return rst && !flush && (!m_valid[i] || (m_grant() == i));
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic m_step();
    int g;
    logic [1:0] rdy;
    g   = m_grant();
    rdy = {m_ready(1), m_ready(0)};
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_valid[i] = 1'b0; m_idx[i] = '0; m_val[i] = '0; m_set[i] = 1'b0; m_nz[i] = '0;
      end
      m_done = 1'b0; m_oidx = '0; m_oval = '0; m_oset = 1'b0; m_onz = '0; m_src = 1'b0;
      m_rr = 0; m_rstd = 1'b1;
    end else if (flush) begin
      m_valid[0] = 1'b0; m_valid[1] = 1'b0; m_done = 1'b0; m_rstd = 1'b0;
    end else begin
      m_rstd = 1'b0;
      if (g >= 0) begin
        m_done = 1'b1; m_oidx = m_idx[g]; m_oval = m_val[g]; m_oset = m_set[g];
        m_onz = m_nz[g]; m_src = g[0]; m_valid[g] = 1'b0; m_rr = (g + 1) % 2;
      end else if (!m_done || bus.in_rob_ready) begin
        m_done = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.in_fu_done[i] && rdy[i]) begin
          m_valid[i] = 1'b1;
          m_idx[i]   = bus.in_fu_dst_rob_index[i*4 +: 4];
          m_val[i]   = bus.in_fu_value[i*64 +: 64];
          m_set[i]   = bus.in_fu_set_nzcv[i];
          m_nz[i]    = bus.in_fu_nzcv[i*4 +: 4];
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic [1:0] d, input logic [3:0] i0,
                       input logic [3:0] i1, input logic [63:0] v0, input logic [63:0] v1,
                       input logic [1:0] s, input logic [7:0] n, input logic rr);
    rst = r; flush = f;
    bus.in_fu_done = d; bus.in_fu_dst_rob_index = {i1, i0}; bus.in_fu_value = {v1, v0};
    bus.in_fu_set_nzcv = s; bus.in_fu_nzcv = n; bus.in_rob_ready = rr;
  endtask

  // One model-checked cycle: ready mid-cycle, registered outputs just after the edge.
  task automatic mcycle(input logic r, input logic f, input logic [1:0] d, input logic [3:0] i0,
                        input logic [3:0] i1, input logic [63:0] v0, input logic [63:0] v1,
                        input logic [1:0] s, input logic [7:0] n, input logic rr);
    drive(r, f, d, i0, i1, v0, v1, s, n, rr);
    #4;
    chk("fu_ready", {62'd0, bus.out_fu_ready}, {62'd0, m_ready(1), m_ready(0)});
    m_step();
    @(posedge clk); #1;
    chk("rob_done", {63'd0, bus.out_rob_done}, {63'd0, m_done});
    if (m_done || m_rstd) begin
      chk("rob_src", {63'd0, bus.out_rob_src_id}, {63'd0, m_src});
      chk("rob_idx", {60'd0, bus.out_rob_dst_rob_index}, {60'd0, m_oidx});
      chk("rob_value", bus.out_rob_value, m_oval);
      chk("rob_set_nzcv", {63'd0, bus.out_rob_set_nzcv}, {63'd0, m_oset});
      chk("rob_nzcv", {60'd0, bus.out_rob_nzcv}, {60'd0, m_onz});
    end
  endtask

  // One table-checked cycle; the model is stepped too so it stays aligned.
  task automatic tcycle(input vec_t v);
    drive(1'b1, v.flush, v.done, v.idx0, v.idx1, v.val0, v.val1, 2'b00, 8'h00, v.rob_ready);
    #4;
    chk("tbl_fu_ready", {62'd0, bus.out_fu_ready}, {62'd0, v.exp_ready});
    m_step();
    @(posedge clk); #1;
    chk("tbl_rob_done", {63'd0, bus.out_rob_done}, {63'd0, v.exp_done});
    if (v.exp_done) begin
      chk("tbl_rob_src", {63'd0, bus.out_rob_src_id}, {63'd0, v.exp_src});
      chk("tbl_rob_idx", {60'd0, bus.out_rob_dst_rob_index}, {60'd0, v.exp_idx});
      chk("tbl_rob_value", bus.out_rob_value, v.exp_val);
    end
  endtask

  initial begin
    checks = 0; failures = 0; m_rr = 0; m_done = 1'b0; m_rstd = 1'b0;
    m_oidx = '0; m_oval = '0; m_oset = 1'b0; m_onz = '0; m_src = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_idx[i] = '0; m_val[i] = '0; m_set[i] = 1'b0; m_nz[i] = '0;
    end
    drive(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 64'h0, 64'h0, 2'b00, 8'h00, 1'b1);
    @(posedge clk); #1;

    // Reset state.
    mcycle(1'b0, 1'b0, 2'b11, 4'h1, 4'h2, 64'h5, 64'h6, 2'b11, 8'hFF, 1'b1);
    mcycle(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 64'h0, 64'h0, 2'b00, 8'h00, 1'b1);

    //                 flush done  idx0  val0     idx1  val1    rr    ready done src idx  value
    tbl.push_back(mk(1'b0, 2'b01, 4'h3, 64'h2A,  4'h0, 64'h0,  1'b1, 2'b11, 1'b0, 1'b0, 4'h0, 64'h0));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b11, 1'b1, 1'b0, 4'h3, 64'h2A));
    tbl.push_back(mk(1'b0, 2'b11, 4'h5, 64'h100, 4'h6, 64'h200, 1'b1, 2'b11, 1'b0, 1'b0, 4'h0, 64'h0));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b10, 1'b1, 1'b1, 4'h6, 64'h200));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b11, 1'b1, 1'b0, 4'h5, 64'h100));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b11, 1'b0, 1'b0, 4'h0, 64'h0));
    tbl.push_back(mk(1'b0, 2'b10, 4'h0, 64'h0,   4'h7, 64'h77, 1'b1, 2'b11, 1'b0, 1'b0, 4'h0, 64'h0));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b11, 1'b1, 1'b1, 4'h7, 64'h77));
    // ALU and LS together with rr_ptr at 0.
    tbl.push_back(mk(1'b0, 2'b11, 4'h1, 64'h11,  4'h2, 64'h22, 1'b1, 2'b11, 1'b0, 1'b0, 4'h0, 64'h0));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b01, 1'b1, 1'b0, 4'h1, 64'h11));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b11, 1'b1, 1'b1, 4'h2, 64'h22));
    // Fill both slots, then stall the ROB for several cycles.
    tbl.push_back(mk(1'b0, 2'b11, 4'h8, 64'h88,  4'h9, 64'h99, 1'b1, 2'b11, 1'b0, 1'b0, 4'h0, 64'h0));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b01, 1'b1, 1'b0, 4'h8, 64'h88));
    tbl.push_back(mk(1'b0, 2'b01, 4'hA, 64'hAA,  4'h0, 64'h0,  1'b1, 2'b11, 1'b1, 1'b1, 4'h9, 64'h99));
    tbl.push_back(mk(1'b0, 2'b10, 4'h0, 64'h0,   4'hB, 64'hBB, 1'b0, 2'b10, 1'b1, 1'b1, 4'h9, 64'h99));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b0, 2'b00, 1'b1, 1'b1, 4'h9, 64'h99));
    tbl.push_back(mk(1'b0, 2'b11, 4'hE, 64'hEE,  4'hF, 64'hFF, 1'b0, 2'b00, 1'b1, 1'b1, 4'h9, 64'h99));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b0, 2'b00, 1'b1, 1'b1, 4'h9, 64'h99));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b01, 1'b1, 1'b0, 4'hA, 64'hAA));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b11, 1'b1, 1'b1, 4'hB, 64'hBB));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b11, 1'b0, 1'b0, 4'h0, 64'h0));
    // Both slots full with a broadcast pending, then flush; rr_ptr must survive it.
    tbl.push_back(mk(1'b0, 2'b11, 4'h1, 64'h1,   4'h2, 64'h2,  1'b1, 2'b11, 1'b0, 1'b0, 4'h0, 64'h0));
    tbl.push_back(mk(1'b0, 2'b01, 4'h3, 64'h3,   4'h0, 64'h0,  1'b1, 2'b01, 1'b1, 1'b0, 4'h1, 64'h1));
    tbl.push_back(mk(1'b1, 2'b11, 4'hC, 64'hCC,  4'hD, 64'hDD, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 64'h0));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b11, 1'b0, 1'b0, 4'h0, 64'h0));
    tbl.push_back(mk(1'b0, 2'b11, 4'h4, 64'h44,  4'h5, 64'h55, 1'b1, 2'b11, 1'b0, 1'b0, 4'h0, 64'h0));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b10, 1'b1, 1'b1, 4'h5, 64'h55));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b11, 1'b1, 1'b0, 4'h4, 64'h44));
    tbl.push_back(mk(1'b0, 2'b00, 4'h0, 64'h0,   4'h0, 64'h0,  1'b1, 2'b11, 1'b0, 1'b0, 4'h0, 64'h0));
    foreach (tbl[r]) tcycle(tbl[r]);

    // Reset mid-stream (with flush also high) after rr_ptr has moved to LS.
    mcycle(1'b1, 1'b0, 2'b01, 4'h6, 4'h0, 64'h66, 64'h0, 2'b01, 8'h05, 1'b1);
    mcycle(1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 64'h0, 64'h0, 2'b00, 8'h00, 1'b1);
    mcycle(1'b0, 1'b1, 2'b11, 4'h7, 4'h8, 64'h77, 64'h88, 2'b11, 8'hFF, 1'b1);
    chk("rst_fu_ready", {62'd0, bus.out_fu_ready}, 64'd0);
    chk("rst_rob_value", bus.out_rob_value, 64'd0);
    mcycle(1'b1, 1'b0, 2'b11, 4'h7, 4'h8, 64'h77, 64'h88, 2'b00, 8'h00, 1'b1);
    mcycle(1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 64'h0, 64'h0, 2'b00, 8'h00, 1'b1);
    chk("post_rst_first_src", {62'd0, bus.out_rob_done, bus.out_rob_src_id}, 64'd2);

    // Both FUs done every cycle: alternating grants, one broadcast per cycle.
    for (int c = 0; c < 12; c++) begin
      mcycle(1'b1, 1'b0, 2'b11, 4'(c), 4'(c + 8), 64'(c * 2), 64'(c * 2 + 1),
             2'(c), 8'(c * 17), 1'b1);
    end

    // Randomized traffic, occasional flush, reset and ROB stalls.
    for (int c = 0; c < 3000; c++) begin
      logic r, f, rr;
      r  = ($urandom_range(0, 59) != 0);
      f  = ($urandom_range(0, 29) == 0);
      rr = ($urandom_range(0, 9) < 7);
      mcycle(r, f, 2'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom},
             {$urandom, $urandom}, 2'($urandom), 8'($urandom), rr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
